// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and FSM encoding for the parametrised LCD controller.
package lcd_ctrl_pkg;

   localparam logic [3:0] CMD_WRITE  = 4'h0;
   localparam logic [3:0] CMD_UP     = 4'h1;
   localparam logic [3:0] CMD_DOWN   = 4'h2;
   localparam logic [3:0] CMD_LEFT   = 4'h3;
   localparam logic [3:0] CMD_RIGHT  = 4'h4;
   localparam logic [3:0] CMD_MAX    = 4'h5;
   localparam logic [3:0] CMD_MIN    = 4'h6;
   localparam logic [3:0] CMD_AVG    = 4'h7;
   localparam logic [3:0] CMD_CCW    = 4'h8;
   localparam logic [3:0] CMD_CW     = 4'h9;
   localparam logic [3:0] CMD_MIRX   = 4'hA;
   localparam logic [3:0] CMD_MIRY   = 4'hB;
   localparam logic [3:0] CMD_RELOAD = 4'hC;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_OP    = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Codes above Reload are reserved: they are dropped without closing the port.
   function automatic logic cmd_known(input logic [3:0] c);
      return (c <= CMD_RELOAD);
   endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator. Pixels not touched by the command pass
// through unchanged, so the top can write all four back unconditionally.
module lcd_win_alu
   import lcd_ctrl_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        cmd_i,
   input  logic [DATA_W-1:0] p0_i,
   input  logic [DATA_W-1:0] p1_i,
   input  logic [DATA_W-1:0] p2_i,
   input  logic [DATA_W-1:0] p3_i,
   output logic [DATA_W-1:0] q0_o,
   output logic [DATA_W-1:0] q1_o,
   output logic [DATA_W-1:0] q2_o,
   output logic [DATA_W-1:0] q3_o
);

   logic [DATA_W-1:0] mx01, mx23, mx, mn01, mn23, mn, avg;
   logic [DATA_W+1:0] sum;

   // Reduction trees; sum carries two guard bits so four full-scale pixels fit.
   always_comb begin
      mx01 = (p0_i > p1_i) ? p0_i : p1_i;
      mx23 = (p2_i > p3_i) ? p2_i : p3_i;
      mx   = (mx01 > mx23) ? mx01 : mx23;
      mn01 = (p0_i < p1_i) ? p0_i : p1_i;
      mn23 = (p2_i < p3_i) ? p2_i : p3_i;
      mn   = (mn01 < mn23) ? mn01 : mn23;
      sum  = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
      avg  = sum[DATA_W+1:2];
   end

   // Per-command result mux.
   always_comb begin
      q0_o = p0_i;
      q1_o = p1_i;
      q2_o = p2_i;
      q3_o = p3_i;
      case (cmd_i)
         CMD_MAX: begin q0_o = mx;  q1_o = mx;  q2_o = mx;  q3_o = mx;  end
         CMD_MIN: begin q0_o = mn;  q1_o = mn;  q2_o = mn;  q3_o = mn;  end
         CMD_AVG: begin q0_o = avg; q1_o = avg; q2_o = avg; q3_o = avg; end
         CMD_CCW: begin q0_o = p1_i; q1_o = p3_i; q3_o = p2_i; q2_o = p0_i; end
         CMD_CW:  begin q0_o = p2_i; q2_o = p3_i; q3_o = p1_i; q1_o = p0_i; end
         CMD_MIRX: begin q0_o = p2_i; q2_o = p0_i; q1_o = p3_i; q3_o = p1_i; end
         CMD_MIRY: begin q0_o = p1_i; q1_o = p0_i; q2_o = p3_i; q3_o = p2_i; end
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised image display controller: fills a local frame buffer from IROM,
// edits a 2x2 window under host commands, and streams the frame to IRAM.
module lcd_ctrl_param
   import lcd_ctrl_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int DATA_W = 8
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [3:0]                               cmd,
   input  logic                                     cmd_valid,
   input  logic [DATA_W-1:0]                        IROM_Q,
   output logic                                     IROM_rd,
   output logic [$clog2(IMG_W)+$clog2(IMG_H)-1:0]   IROM_A,
   output logic                                     IRAM_valid,
   output logic [DATA_W-1:0]                        IRAM_D,
   output logic [$clog2(IMG_W)+$clog2(IMG_H)-1:0]   IRAM_A,
   output logic                                     busy,
   output logic                                     done
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int AW = XW + YW;
   localparam int N  = IMG_W * IMG_H;

   localparam logic [XW-1:0] X_RST = XW'(IMG_W / 2);
   localparam logic [YW-1:0] Y_RST = YW'(IMG_H / 2);
   localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_ONE = XW'(1);
   localparam logic [YW-1:0] Y_ONE = YW'(1);
   localparam logic [AW:0]   CNT_N = (AW+1)'(N);
   localparam logic [AW:0]   CNT_1 = (AW+1)'(1);

   state_e              state_q, state_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [AW:0]         cnt_q, cnt_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic                rd_q, rd_d;
   logic [AW-1:0]       roma_q, roma_d;
   logic                rd1_q;
   logic [AW-1:0]       ra1_q;
   logic                ramv_q, ramv_d;
   logic [DATA_W-1:0]   ramd_q, ramd_d;
   logic [AW-1:0]       rama_q, rama_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   mem_q [N];

   logic                accept, last_fill;
   logic [XW-1:0]       xm;
   logic [YW-1:0]       ym;
   logic [AW-1:0]       a0, a1, a2, a3;
   logic [DATA_W-1:0]   q0, q1, q2, q3;

   // busy_q is low only in IDLE/DONE, so it alone gates the command port.
   assign accept    = cmd_valid && !busy_q && cmd_known(cmd);
   // Last IROM word lands once issuing has stopped and the final read is in flight.
   assign last_fill = (cnt_q == CNT_N) && !rd_q && rd1_q;

   // Window pixel addresses, {y,x} row-major.
   always_comb begin
      xm = x_q - X_ONE;
      ym = y_q - Y_ONE;
      a0 = {ym,  xm};
      a1 = {ym,  x_q};
      a2 = {y_q, xm};
      a3 = {y_q, x_q};
   end

   lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
      .cmd_i (cmd_q),
      .p0_i  (mem_q[a0]),
      .p1_i  (mem_q[a1]),
      .p2_i  (mem_q[a2]),
      .p3_i  (mem_q[a3]),
      .q0_o  (q0),
      .q1_o  (q1),
      .q2_o  (q2),
      .q3_o  (q3)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_LOAD;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:  if (last_fill) state_d = ST_IDLE;
         ST_IDLE,
         ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               case (cmd)
                  CMD_WRITE:  state_d = ST_WRITE;
                  CMD_RELOAD: state_d = ST_LOAD;
                  default:    state_d = ST_OP;
               endcase
            end
         end
         ST_OP:    state_d = ST_IDLE;
         ST_WRITE: if (cnt_q == CNT_N) state_d = ST_DONE;
         default:  state_d = ST_LOAD;
      endcase
   end

   // Next values of the counters, origin and all registered outputs.
   always_comb begin
      cmd_d  = cmd_q;
      cnt_d  = cnt_q;
      x_d    = x_q;
      y_d    = y_q;
      rd_d   = 1'b0;
      roma_d = roma_q;
      ramv_d = 1'b0;
      ramd_d = ramd_q;
      rama_d = rama_q;
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
      case (state_q)
         ST_LOAD: begin
            if (cnt_q != CNT_N) begin
               rd_d   = 1'b1;
               roma_d = cnt_q[AW-1:0];
               cnt_d  = cnt_q + CNT_1;
            end
         end
         ST_IDLE,
         ST_DONE: begin
            if (accept) begin
               cmd_d = cmd;
               if (cmd == CMD_WRITE) begin
                  // First pixel goes out in the cycle right after acceptance.
                  ramv_d = 1'b1;
                  rama_d = '0;
                  ramd_d = mem_q[0];
                  cnt_d  = CNT_1;
               end else if (cmd == CMD_RELOAD) begin
                  cnt_d  = '0;
               end
            end
         end
         ST_OP: begin
            case (cmd_q)
               CMD_UP:    if (y_q > Y_ONE) y_d = y_q - Y_ONE;
               CMD_DOWN:  if (y_q < Y_MAX) y_d = y_q + Y_ONE;
               CMD_LEFT:  if (x_q > X_ONE) x_d = x_q - X_ONE;
               CMD_RIGHT: if (x_q < X_MAX) x_d = x_q + X_ONE;
               default: ;
            endcase
         end
         ST_WRITE: begin
            if (cnt_q != CNT_N) begin
               ramv_d = 1'b1;
               rama_d = cnt_q[AW-1:0];
               ramd_d = mem_q[cnt_q[AW-1:0]];
               cnt_d  = cnt_q + CNT_1;
            end
         end
         default: ;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_q  <= CMD_WRITE;
         cnt_q  <= '0;
         x_q    <= X_RST;
         y_q    <= Y_RST;
         rd_q   <= 1'b0;
         roma_q <= '0;
         rd1_q  <= 1'b0;
         ra1_q  <= '0;
         ramv_q <= 1'b0;
         ramd_q <= '0;
         rama_q <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         cmd_q  <= cmd_d;
         cnt_q  <= cnt_d;
         x_q    <= x_d;
         y_q    <= y_d;
         rd_q   <= rd_d;
         roma_q <= roma_d;
         rd1_q  <= rd_q;
         ra1_q  <= roma_q;
         ramv_q <= ramv_d;
         ramd_q <= ramd_d;
         rama_q <= rama_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // Frame buffer: IROM fill during LOAD, window write-back at the end of OP.
   always_ff @(posedge clk) begin
      if (rd1_q) mem_q[ra1_q] <= IROM_Q;
      if (state_q == ST_OP) begin
         mem_q[a0] <= q0;
         mem_q[a1] <= q1;
         mem_q[a2] <= q2;
         mem_q[a3] <= q3;
      end
   end

   assign IROM_rd    = rd_q;
   assign IROM_A     = roma_q;
   assign IRAM_valid = ramv_q;
   assign IRAM_D     = ramd_q;
   assign IRAM_A     = rama_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench: 8x8x8 controller plus a 16x4x10 instance sharing clock/reset.
module tb_lcd_ctrl_param;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8x8, DATA_W=8
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] irom_q;
   logic       irom_rd, iram_valid, busy, done;
   logic [5:0] irom_a, iram_a;
   logic [7:0] iram_d;

   // 16x4, DATA_W=10
   logic [3:0] cmd2;
   logic       v2;
   logic [9:0] irom_q2;
   logic       irom_rd2, iram_valid2, busy2, done2;
   logic [5:0] irom_a2, iram_a2;
   logic [9:0] iram_d2;

   lcd_ctrl_param dut (
      .clk(clk), .reset(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
      .IROM_Q(irom_q), .IROM_rd(irom_rd), .IROM_A(irom_a),
      .IRAM_valid(iram_valid), .IRAM_D(iram_d), .IRAM_A(iram_a),
      .busy(busy), .done(done)
   );

   lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DATA_W(10)) dut2 (
      .clk(clk), .reset(rst_n), .cmd(cmd2), .cmd_valid(v2),
      .IROM_Q(irom_q2), .IROM_rd(irom_rd2), .IROM_A(irom_a2),
      .IRAM_valid(iram_valid2), .IRAM_D(iram_d2), .IRAM_A(iram_a2),
      .busy(busy2), .done(done2)
   );

   logic [7:0] rom [64];
   logic [7:0] ram [64];
   logic [7:0] exp_img [64];
   logic [9:0] rom2 [64];
   logic [9:0] ram2 [64];
   logic [9:0] exp2 [64];
   int wcnt = 0, wbase = 0, seq_bad = 0;
   int wcnt2 = 0, wbase2 = 0, seq_bad2 = 0;
   int checks = 0, fails = 0;

   // IROM: synchronous read; IRAM: capture writes and watch address order.
   always @(posedge clk) begin
      if (irom_rd)  irom_q  <= rom[irom_a];
      if (irom_rd2) irom_q2 <= rom2[irom_a2];
      if (iram_valid) begin
         ram[iram_a] <= iram_d;
         if (int'(iram_a) != wcnt - wbase) seq_bad <= seq_bad + 1;
         wcnt <= wcnt + 1;
      end
      if (iram_valid2) begin
         ram2[iram_a2] <= iram_d2;
         if (int'(iram_a2) != wcnt2 - wbase2) seq_bad2 <= seq_bad2 + 1;
         wcnt2 <= wcnt2 + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 300) begin tick(); n++; end
      chk(tag, {31'd0, busy}, 0);
   endtask

   // Issue one command on the 8x8 port; nb = busy cycles after acceptance.
   task automatic issue(input logic [3:0] c, output int nb);
      cmd = c; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      nb = 0;
      while (busy && nb < 300) begin tick(); nb++; end
   endtask

   // Write the 8x8 frame out and compare against exp_img.
   task automatic do_write(input string tag, input bit hold_mirx);
      int n = 0, bad = 0;
      wbase = wcnt;
      n = seq_bad;
      cmd = 4'h0; cmd_valid = 1'b1;
      tick();
      if (hold_mirx) cmd = 4'hA;
      else cmd_valid = 1'b0;
      bad = 0;
      while (!done && bad < 300) begin tick(); bad++; end
      cmd_valid = 1'b0;
      chk({tag, "_done"}, {31'd0, done}, 1);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
      chk({tag, "_nwrites"}, wcnt - wbase, 64);
      chk({tag, "_addr_order"}, seq_bad - n, 0);
      tick();
      chk({tag, "_done_pulse"}, {31'd0, done}, 0);
      bad = 0;
      for (int k = 0; k < 64; k++) if (ram[k] !== exp_img[k]) bad++;
      chk({tag, "_image"}, bad, 0);
   endtask

   initial begin
      int nb, fall, bad;
      rst_n = 1'b0; cmd = 4'h0; cmd_valid = 1'b0; cmd2 = 4'h0; v2 = 1'b0;
      for (int k = 0; k < 64; k++) begin
         rom[k] = 8'(k); exp_img[k] = 8'(k);
         rom2[k] = 10'(k); exp2[k] = 10'(k);
      end
      rom2[23] = 10'd1023; rom2[24] = 10'd1023; rom2[39] = 10'd1023; rom2[40] = 10'd1023;
      exp2[23] = 10'd1023; exp2[24] = 10'd1023; exp2[39] = 10'd1023; exp2[40] = 10'd1023;
      repeat (3) tick();

      chk("rst_busy", {31'd0, busy}, 1);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_irom_rd", {31'd0, irom_rd}, 0);
      chk("rst_irom_a", {26'd0, irom_a}, 0);
      chk("rst_iram_valid", {31'd0, iram_valid}, 0);
      chk("rst_iram_a", {26'd0, iram_a}, 0);

      // Load sweep: reads in cycles 0..63, busy drops at cycle 65.
      rst_n = 1'b1;
      bad = 0; fall = -1;
      for (int c = 0; c < 70; c++) begin
         tick();
         if (c < 64 && (irom_rd !== 1'b1 || irom_a !== 6'(c))) bad++;
         if (c == 64 && irom_rd !== 1'b0) bad++;
         if (c < 64 && busy !== 1'b1) bad++;
         if (fall < 0 && busy === 1'b0) fall = c;
      end
      chk("load_sweep", bad, 0);
      chk("busy_fall_cycle", fall, 65);

      // Write with MirrorX held on the port; it must be ignored.
      do_write("wr1", 1'b1);
      do_write("wr2", 1'b0);

      // Reserved command: no busy, no change.
      cmd = 4'hF; cmd_valid = 1'b1;
      tick();
      chk("cmdF_busy0", {31'd0, busy}, 0);
      cmd_valid = 1'b0;
      tick();
      chk("cmdF_busy1", {31'd0, busy}, 0);
      do_write("wr_cmdF", 1'b0);

      // Average at (4,4) on modified pixels: (10+20+30+41)/4 = 25.
      rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd41;
      issue(4'hC, nb);
      chk("reload_done", {31'd0, busy}, 0);
      issue(4'h7, nb);
      chk("avg_busy_cycles", nb, 1);
      exp_img[27] = 8'd25; exp_img[28] = 8'd25; exp_img[35] = 8'd25; exp_img[36] = 8'd25;
      do_write("wr_avg", 1'b0);

      // Reload restores modified pixels; Max -> 41.
      issue(4'hC, nb);
      issue(4'h5, nb);
      exp_img[27] = 8'd41; exp_img[28] = 8'd41; exp_img[35] = 8'd41; exp_img[36] = 8'd41;
      do_write("wr_max", 1'b0);

      // Default image, walk the window to (1,1), then the rotate/mirror/min chain.
      rom[27] = 8'd27; rom[28] = 8'd28; rom[35] = 8'd35; rom[36] = 8'd36;
      issue(4'hC, nb);
      for (int k = 0; k < 64; k++) exp_img[k] = 8'(k);
      for (int i = 0; i < 4; i++) begin
         issue(4'h3, nb);
         chk($sformatf("left%0d_busy", i), nb, 1);
      end
      for (int i = 0; i < 4; i++) issue(4'h1, nb);
      issue(4'h9, nb);
      issue(4'h4, nb); issue(4'hB, nb);
      issue(4'h2, nb); issue(4'hA, nb);
      issue(4'h4, nb); issue(4'h6, nb);
      issue(4'h2, nb); issue(4'h8, nb);
      exp_img[0] = 8'd8;   exp_img[1] = 8'd2;   exp_img[2] = 8'd0;
      exp_img[8] = 8'd9;   exp_img[9] = 8'd17;  exp_img[10] = 8'd1;
      exp_img[11] = 8'd1;  exp_img[17] = 8'd10; exp_img[18] = 8'd1;
      exp_img[19] = 8'd27; exp_img[26] = 8'd1;  exp_img[27] = 8'd26;
      do_write("wr_chain", 1'b0);

      // Reset in write cycle 20.
      cmd = 4'h0; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (20) tick();
      chk("midwr_valid", {31'd0, iram_valid}, 1);
      chk("midwr_addr", {26'd0, iram_a}, 20);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, iram_valid}, 0);
      chk("midrst_busy", {31'd0, busy}, 1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("reload_rd", {31'd0, irom_rd}, 1);
      chk("reload_a", {26'd0, irom_a}, 0);
      wait_idle("reload_idle");
      for (int k = 0; k < 64; k++) exp_img[k] = 8'(k);
      do_write("wr_after_rst", 1'b0);

      // 16x4x10 instance: Average of four 1023s at origin (8,2), then Write.
      bad = 0;
      while (busy2 && bad < 300) begin tick(); bad++; end
      chk("v2_idle", {31'd0, busy2}, 0);
      cmd2 = 4'h7; v2 = 1'b1;
      tick();
      v2 = 1'b0;
      chk("v2_avg_busy", {31'd0, busy2}, 1);
      tick();
      chk("v2_avg_free", {31'd0, busy2}, 0);
      wbase2 = wcnt2; nb = seq_bad2;
      cmd2 = 4'h0; v2 = 1'b1;
      tick();
      v2 = 1'b0;
      bad = 0;
      while (!done2 && bad < 300) begin tick(); bad++; end
      chk("v2_done", {31'd0, done2}, 1);
      chk("v2_nwrites", wcnt2 - wbase2, 64);
      chk("v2_addr_order", seq_bad2 - nb, 0);
      tick();
      bad = 0;
      for (int k = 0; k < 64; k++) if (ram2[k] !== exp2[k]) bad++;
      chk("v2_image", bad, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
